// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - state encodings, address-width default and speed helper for aud_mode_ctrl
package aud_pkg;

  localparam int ADDR_W_DEF = 20;

  // These encodings are what o_state reports.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REC        = 3'd1,
    ST_REC_PAUSE  = 3'd2,
    ST_PLAY       = 3'd3,
    ST_PLAY_PAUSE = 3'd4
  } aud_state_e;

  function automatic logic [2:0] sat_speed(input logic [2:0] sw);
    return (sw == 3'd0) ? 3'd1 : sw;
  endfunction

endpackage

// File: rtl/aud_mode_ctrl.sv
// rtl/aud_mode_ctrl.sv - record/play mode FSM arbitrating SRAM between recorder and AudDSP
// Optional: AUD_MODE_CTRL_LIVE_CFG_EN re-latches playback switches every PLAY cycle.
module aud_mode_ctrl
  import aud_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_record,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic              i_sw_fast,
  input  logic              i_sw_interp,
  input  logic [2:0]        i_sw_speed,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic              o_fast,
  output logic              o_interp,
  output logic [2:0]        o_speed,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_sram_owner,
  output logic [2:0]        o_state
);

  aud_state_e        state_q;
  logic              rec_start_q, rec_pause_q, rec_stop_q;
  logic              dsp_start_q, dsp_pause_q, dsp_stop_q;
  logic              fast_q, interp_q;
  logic [2:0]        speed_q;
  logic [ADDR_W-1:0] end_addr_q;
  logic              owner_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      rec_start_q <= 1'b0;
      rec_pause_q <= 1'b0;
      rec_stop_q  <= 1'b0;
      dsp_start_q <= 1'b0;
      dsp_pause_q <= 1'b0;
      dsp_stop_q  <= 1'b0;
      fast_q      <= 1'b0;
      interp_q    <= 1'b0;
      speed_q     <= 3'd1;
      end_addr_q  <= '0;
      owner_q     <= 1'b0;
    end else begin
      rec_start_q <= 1'b0;
      rec_pause_q <= 1'b0;
      rec_stop_q  <= 1'b0;
      dsp_start_q <= 1'b0;
      dsp_pause_q <= 1'b0;
      dsp_stop_q  <= 1'b0;
      case (state_q)
        // Stop and pause are meaningless here, so record/play act even if they coincide.
        ST_IDLE: begin
          if (i_key_record) begin
            state_q     <= ST_REC;
            rec_start_q <= 1'b1;
            owner_q     <= 1'b1;
          end else if (i_key_play && (end_addr_q != '0)) begin
            state_q     <= ST_PLAY;
            dsp_start_q <= 1'b1;
            fast_q      <= i_sw_fast;
            interp_q    <= i_sw_interp;
            speed_q     <= sat_speed(i_sw_speed);
          end
        end
        ST_REC, ST_REC_PAUSE: begin
          if (i_key_stop || (state_q == ST_REC && i_rec_addr == MAX_ADDR)) begin
            state_q    <= ST_IDLE;
            rec_stop_q <= 1'b1;
            end_addr_q <= i_rec_addr;
            owner_q    <= 1'b0;
          end else if (state_q == ST_REC) begin
            if (i_key_pause) begin
              state_q     <= ST_REC_PAUSE;
              rec_pause_q <= 1'b1;
            end
          end else if (i_key_pause || i_key_record) begin
            state_q     <= ST_REC;
            rec_start_q <= 1'b1;
          end
        end
        ST_PLAY, ST_PLAY_PAUSE: begin
`ifdef AUD_MODE_CTRL_LIVE_CFG_EN
          if (state_q == ST_PLAY) begin
            fast_q   <= i_sw_fast;
            interp_q <= i_sw_interp;
            speed_q  <= sat_speed(i_sw_speed);
          end
`endif
          if (i_key_stop || (state_q == ST_PLAY && i_play_addr >= end_addr_q)) begin
            state_q    <= ST_IDLE;
            dsp_stop_q <= 1'b1;
          end else if (state_q == ST_PLAY) begin
            if (i_key_pause) begin
              state_q     <= ST_PLAY_PAUSE;
              dsp_pause_q <= 1'b1;
            end
          end else if (i_key_pause || i_key_play) begin
            state_q     <= ST_PLAY;
            dsp_start_q <= 1'b1;
            fast_q      <= i_sw_fast;
            interp_q    <= i_sw_interp;
            speed_q     <= sat_speed(i_sw_speed);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          owner_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_rec_start  = rec_start_q;
  assign o_rec_pause  = rec_pause_q;
  assign o_rec_stop   = rec_stop_q;
  assign o_dsp_start  = dsp_start_q;
  assign o_dsp_pause  = dsp_pause_q;
  assign o_dsp_stop   = dsp_stop_q;
  assign o_fast       = fast_q;
  assign o_interp     = interp_q;
  assign o_speed      = speed_q;
  assign o_end_addr   = end_addr_q;
  assign o_sram_owner = owner_q;
  assign o_state      = state_q;

endmodule

// File: doc/aud_mode_ctrl.md
AUD_MODE_CTRL -- requirements
Module: aud_mode_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 The block SHALL have parameter MAX_ADDR, default 2**ADDR_W-1, last recordable address.
REQ-003 Port i_clk  in  1  single clock.
REQ-004 Port i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 Ports i_key_record, i_key_play, i_key_pause, i_key_stop  in  1 each  single-cycle command pulses.
REQ-006 Ports i_sw_fast, i_sw_interp  in  1 each; i_sw_speed  in  3: playback configuration switches.
REQ-007 Port i_rec_addr  in  ADDR_W  recorder's current write address.
REQ-008 Port i_play_addr  in  ADDR_W  DSP's current SRAM read address.
REQ-009 Ports o_rec_start, o_rec_pause, o_rec_stop  out  1 each  single-cycle pulses to the recorder.
REQ-010 Ports o_dsp_start, o_dsp_pause, o_dsp_stop  out  1 each  single-cycle pulses to AudDSP.
REQ-011 Ports o_fast, o_interp  out  1; o_speed  out  3: latched DSP configuration.
REQ-012 Port o_end_addr  out  ADDR_W  last recorded address.
REQ-013 Port o_sram_owner  out  1  0 = DSP reads SRAM, 1 = recorder writes SRAM.
REQ-014 Port o_state  out  3  current FSM state encoding.

Function
REQ-015 The FSM SHALL have states IDLE, REC, REC_PAUSE, PLAY, PLAY_PAUSE.
REQ-016 All outputs SHALL be registered; each command pulse SHALL appear exactly one cycle after the causing key or condition.
REQ-017 Same-cycle key priority SHALL be stop > pause > record > play.
REQ-018 IDLE+record SHALL go to REC, pulse o_rec_start, set o_sram_owner=1.
REQ-019 IDLE+play SHALL go to PLAY and pulse o_dsp_start only if o_end_addr != 0; otherwise it SHALL stay in IDLE.
REQ-020 REC+pause SHALL go to REC_PAUSE with o_rec_pause; REC_PAUSE+record or +pause SHALL return to REC with o_rec_start.
REQ-021 PLAY+pause SHALL go to PLAY_PAUSE with o_dsp_pause; PLAY_PAUSE+play or +pause SHALL return to PLAY with o_dsp_start.
REQ-022 Stop in REC or REC_PAUSE SHALL pulse o_rec_stop, capture o_end_addr=i_rec_addr, go to IDLE, and set o_sram_owner=0.
REQ-023 Stop in PLAY or PLAY_PAUSE SHALL pulse o_dsp_stop and go to IDLE; o_end_addr SHALL be unchanged.
REQ-024 In REC, i_rec_addr == MAX_ADDR SHALL act as stop (auto-stop, o_end_addr=MAX_ADDR).
REQ-025 In PLAY, i_play_addr >= o_end_addr SHALL act as stop (end of recording).
REQ-026 Record in PLAY/PLAY_PAUSE and play in REC/REC_PAUSE SHALL be ignored; stop or pause in IDLE SHALL be ignored.
REQ-027 o_fast/o_speed/o_interp SHALL be latched from switches on every o_dsp_start; i_sw_speed==0 SHALL latch as 1 (speed saturates to range 1..7).
REQ-028 o_sram_owner SHALL be 1 exactly in REC and REC_PAUSE.

Reset
REQ-029 While i_rst_n is low at a clock edge: state IDLE, all pulses 0, o_fast=0, o_speed=1, o_interp=0, o_end_addr=0, o_sram_owner=0.
REQ-030 Reset mid-REC or mid-PLAY SHALL discard the session without emitting any stop pulse.

Configuration
REQ-031 With AUD_MODE_CTRL_LIVE_CFG_EN defined, o_fast/o_speed/o_interp SHALL also re-latch from switches every cycle in PLAY (same speed-0 rule).
REQ-032 Without AUD_MODE_CTRL_LIVE_CFG_EN, configuration SHALL change only on o_dsp_start.

Structure
REQ-033 Package aud_pkg SHALL hold the state enum typedef, the ADDR_W default constant and the state encodings driven on o_state.
REQ-034 The block SHALL be a single module; no sub-module.

Verification
REQ-035 Reset, then play with o_end_addr=0 -> no o_dsp_start; state stays IDLE.
REQ-036 Record, then stop when i_rec_addr=0x00123 -> o_rec_start, then o_rec_stop; o_end_addr=0x00123; o_sram_owner returns to 0.
REQ-037 Play with i_sw_speed=0, i_sw_fast=1, then i_play_addr ramps to 0x00123 -> o_speed=1, o_fast=1; single o_dsp_stop; state IDLE.
REQ-038 Pause and stop in the same cycle during PLAY -> only o_dsp_stop; state IDLE.
REQ-039 Record held until i_rec_addr=MAX_ADDR -> auto o_rec_stop; o_end_addr=0xFFFFF.
REQ-040 Change i_sw_speed from 2 to 5 mid-PLAY -> o_speed=5 next cycle with AUD_MODE_CTRL_LIVE_CFG_EN defined; stays 2 without it.
